pad_pwr_seq: RTL

- Power-up/power-down sequencer for the chip I/O pad ring.
- Sits between the core and the signal pads. Gates per-pad output enable (OE) and input enable (IE) by group.
- On power-up, waits a settle period after power-on control, then enables pad groups one at a time, staggered. This limits simultaneous switching noise on the small set of IO VDD/VSS pads.
- On power-down, disables groups in reverse order.

---
 rtl/pad_pwr_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pad_pwr_seq.sv
// pad_pwr_seq: staggered power-up / power-down sequencer for the I/O pad ring.
// Enables pad groups one at a time after a settle period so the shared IO
// supply pads see limited simultaneous switching. Groups are disabled in
// reverse order. Per-pad OE/IE are gated by the registered group enables.
//
// Optional build macro: PAD_PWR_SEQ_TESTMODE_EN
//   Adds test_mode_i. While high, pads bypass the sequencer (OE follows the
//   core request, IE forced on), the FSM and counter freeze, and ready_o is 1.
module pad_pwr_seq #(
    parameter int NUM_GROUPS     = 4,
    parameter int PADS_PER_GRP   = 8,
    parameter int SETTLE_CYCLES  = 256,
    parameter int STAGGER_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 en_i,
`ifdef PAD_PWR_SEQ_TESTMODE_EN
    input  logic                                 test_mode_i,
`endif
    input  logic [NUM_GROUPS*PADS_PER_GRP-1:0]   oe_req_i,
    output logic [NUM_GROUPS*PADS_PER_GRP-1:0]   pad_oe_o,
    output logic [NUM_GROUPS*PADS_PER_GRP-1:0]   pad_ie_o,
    output logic [NUM_GROUPS-1:0]                grp_en_o,
    output logic                                 ready_o,
    output logic                                 busy_o,
    output logic [2:0]                           state_o
);

    localparam int NP = NUM_GROUPS * PADS_PER_GRP;

    localparam logic [CNT_W-1:0]      SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE      = CNT_W'(1);
    localparam logic [NUM_GROUPS-1:0] GRP_ONE      = NUM_GROUPS'(1);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_RAMP_UP = 3'd2,
        ST_ON      = 3'd3,
        ST_RAMP_DN = 3'd4
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [NUM_GROUPS-1:0]   grp_en_reg;
    logic                    ready_reg;
    logic                    busy_reg;

    // Freeze request for the sequencer; only the test-mode build can assert it.
    logic hold;
`ifdef PAD_PWR_SEQ_TESTMODE_EN
    assign hold = test_mode_i;
`else
    assign hold = 1'b0;
`endif

    // Thermometer neighbours of the current group vector: one more / one fewer group.
    logic [NUM_GROUPS-1:0] grp_up;
    logic [NUM_GROUPS-1:0] grp_dn;
    logic                  grp_full;
    logic                  grp_dn_empty;

    assign grp_up       = (grp_en_reg << 1) | GRP_ONE;
    assign grp_dn       = grp_en_reg >> 1;
    assign grp_full     = &grp_en_reg;
    assign grp_dn_empty = (grp_dn == '0);

    // Sequencer FSM with registered group enables, ready and busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= ST_OFF;
            cnt_reg    <= '0;
            grp_en_reg <= '0;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else if (!hold) begin
            case (state_reg)
                ST_OFF: begin
                    if (en_i) begin
                        state_reg <= ST_SETTLE;
                        cnt_reg   <= SETTLE_LOAD;
                        busy_reg  <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (!en_i) begin
                        // Aborted before any group was enabled.
                        state_reg <= ST_OFF;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else if (cnt_reg == '0) begin
                        state_reg  <= ST_RAMP_UP;
                        grp_en_reg <= GRP_ONE;
                        cnt_reg    <= STAGGER_LOAD;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end

                ST_RAMP_UP: begin
                    if (!en_i) begin
                        // Reverse immediately: drop the top group on this edge.
                        grp_en_reg <= grp_dn;
                        if (grp_dn_empty) begin
                            state_reg <= ST_OFF;
                            cnt_reg   <= '0;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= ST_RAMP_DN;
                            cnt_reg   <= STAGGER_LOAD;
                        end
                    end else if (cnt_reg == '0) begin
                        if (grp_full) begin
                            // Last group has had its full stagger interval.
                            state_reg <= ST_ON;
                            ready_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            grp_en_reg <= grp_up;
                            cnt_reg    <= STAGGER_LOAD;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end

                ST_ON: begin
                    if (!en_i) begin
                        ready_reg  <= 1'b0;
                        grp_en_reg <= grp_dn;
                        if (grp_dn_empty) begin
                            state_reg <= ST_OFF;
                            cnt_reg   <= '0;
                        end else begin
                            state_reg <= ST_RAMP_DN;
                            cnt_reg   <= STAGGER_LOAD;
                            busy_reg  <= 1'b1;
                        end
                    end
                end

                ST_RAMP_DN: begin
                    if (en_i) begin
                        // Resume ramping up from the current top; no settle needed.
                        state_reg  <= ST_RAMP_UP;
                        grp_en_reg <= grp_up;
                        cnt_reg    <= STAGGER_LOAD;
                    end else if (cnt_reg == '0) begin
                        grp_en_reg <= grp_dn;
                        if (grp_dn_empty) begin
                            state_reg <= ST_OFF;
                            cnt_reg   <= '0;
                            busy_reg  <= 1'b0;
                        end else begin
                            cnt_reg <= STAGGER_LOAD;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end

                default: begin
                    state_reg  <= ST_OFF;
                    cnt_reg    <= '0;
                    grp_en_reg <= '0;
                    ready_reg  <= 1'b0;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    // Per-pad gating: each pad follows the enable of the group it belongs to.
    for (genvar gi = 0; gi < NP; gi++) begin : g_pad
        localparam int GRP = gi / PADS_PER_GRP;
        assign pad_oe_o[gi] = hold ? oe_req_i[gi] : (grp_en_reg[GRP] & oe_req_i[gi]);
        assign pad_ie_o[gi] = hold | grp_en_reg[GRP];
    end

    assign grp_en_o = grp_en_reg;
    assign ready_o  = ready_reg | hold;
    assign busy_o   = busy_reg;
    assign state_o  = state_reg;

endmodule
